muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request a new multiply/divide operation.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  operand A, driven from register-file read port rd1 (dividend / multiplicand).
REQ-007 b  input  32  operand B, driven from register-file read port rd2 (divisor / multiplier).
REQ-008 mthi  input  1  write a into HI (MTHI).
REQ-009 mtlo  input  1  write a into LO (MTLO).
REQ-010 busy  output  1  operation in progress; the CPU stalls MFHI/MFLO/start while high.
REQ-011 done  output  1  single-cycle pulse when HI/LO receive a new result.
REQ-012 hi  output  32  HI register contents.
REQ-013 lo  output  32  LO register contents.

Function
REQ-014 The block SHALL have states IDLE and RUN; reset and power-up state is IDLE.
REQ-015 In IDLE, start=1 on a rising edge SHALL latch op, a, b, and enter RUN; busy SHALL be 1 from the next cycle.
REQ-016 RUN SHALL last exactly 32 cycles: one iteration per edge, shift-add for multiply, restoring subtract-shift for divide.
REQ-017 On the 32nd RUN edge, HI/LO SHALL load the result, the block SHALL return to IDLE, and in the following cycle busy=0 and done=1.
REQ-018 done SHALL be 1 for exactly one cycle per completed operation and 0 otherwise.
REQ-019 MULT/MULTU: {HI,LO} SHALL equal the full 64-bit product, signed (MULT) or unsigned (MULTU).
REQ-020 DIV/DIVU: LO SHALL equal the quotient and HI the remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-021 Signed operations SHALL iterate on magnitudes and apply sign correction when results are written back.
REQ-022 Divide by zero (b=0) SHALL give LO=32'hFFFFFFFF and HI=a, for both signed and unsigned divide, with the same 32-cycle latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-024 hi/lo SHALL hold their previous values throughout RUN; intermediate iteration state SHALL NOT be visible.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 mthi/mtlo in IDLE SHALL write a into HI/LO on that edge; asserting both SHALL write both.
REQ-027 mthi/mtlo while busy=1 SHALL be ignored.
REQ-028 If start and mthi/mtlo are asserted on the same IDLE edge, start SHALL win and the move SHALL be ignored.
REQ-029 Operand changes on a/b after the accepting edge SHALL NOT affect the result.
REQ-030 Back-to-back operation: start asserted in the done cycle SHALL be accepted.

Reset
REQ-031 reset=1 SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0 on the next rising edge.
REQ-032 reset SHALL take priority over start, mthi, mtlo and any in-flight operation; a reset during RUN SHALL abort it with no done pulse.
REQ-033 After reset deasserts, start SHALL be accepted on the first edge.

Verification
REQ-034 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 32 busy cycles: done=1, HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-035 MULT a=-7 (32'hFFFFFFF9), b=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; busy high exactly 32 cycles.
REQ-036 DIV a=-7, b=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU a=100, b=7 -> LO=14, HI=2.
REQ-037 DIVU a=5, b=0 -> LO=32'hFFFFFFFF, HI=5; DIV 32'h80000000 by 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-038 MTHI a=32'h1234 in IDLE -> HI=32'h1234 next cycle; MTLO or a second start during busy -> HI/LO unchanged and no extra done pulse.
REQ-039 Reset asserted at RUN cycle 10 -> next cycle busy=0, HI=LO=0, and no done pulse for the aborted operation.

Source files
------------

// File: rtl/muldiv_if.sv
// Multiply/divide unit handshake bundle: request side plus HI/LO result side.
interface muldiv_if;
    localparam int unsigned W = 32;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One iteration per cycle for 32 cycles; signed ops run on magnitudes
// and the signs are restored when HI/LO are written.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_b;

    logic           op_signed;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     sum;
    logic [W:0]     rem_cat;
    logic           ge;
    logic [W-1:0]   step_hi;
    logic [W-1:0]   step_lo;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // Operand magnitudes, one iteration step, and sign-corrected final results.
    always_comb begin
        op_signed = ~bus.op[0];
        sign_a    = op_signed & bus.a[W-1];
        sign_b    = op_signed & bus.b[W-1];
        mag_a     = sign_a ? W'(-bus.a) : bus.a;
        mag_b     = sign_b ? W'(-bus.b) : bus.b;

        sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : (W+1)'(0));
        rem_cat = {w_hi, w_lo[W-1]};
        ge      = rem_cat >= {1'b0, w_b};

        step_hi = sum[W:1];
        step_lo = {sum[0], w_lo[W-1:1]};
        if (is_div) begin
            // Restoring divide: partial remainder always fits 32 bits after the step
            step_hi = ge ? (rem_cat[W-1:0] - w_b) : rem_cat[W-1:0];
            step_lo = {w_lo[W-2:0], ge};
        end

        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? (2*W)'(-prod) : prod;
        quo_fix  = neg_q ? W'(-step_lo) : step_lo;
        rem_fix  = neg_r ? W'(-step_hi) : step_hi;
    end

    // Control FSM, iteration registers and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            w_hi     <= '0;
            w_lo     <= '0;
            w_b      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        w_hi     <= '0;
                        w_lo     <= bus.op[1] ? mag_a : mag_b;
                        w_b      <= bus.op[1] ? mag_b : mag_a;
                        // Divide by zero keeps an all-ones quotient regardless of sign
                        neg_q    <= bus.op[1] ? ((sign_a ^ sign_b) & (bus.b != '0))
                                              : (sign_a ^ sign_b);
                        neg_r    <= sign_a;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        if (bus.mthi) bus.hi <= bus.a;
                        if (bus.mtlo) bus.lo <= bus.a;
                    end
                end
                RUN: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) begin
                        if (is_div) begin
                            bus.hi <= rem_fix;
                            bus.lo <= quo_fix;
                        end else begin
                            bus.hi <= prod_fix[2*W-1:W];
                            bus.lo <= prod_fix[W-1:0];
                        end
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, scramble inputs after acceptance, optionally poke start/mthi/mtlo mid-run.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic disturb);
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        int          cyc;
        logic        early_done;
        logic        held_bad;
        hold_hi    = bus.hi;
        hold_lo    = bus.lo;
        cyc        = 0;
        early_done = 1'b0;
        held_bad   = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = 32'hDEADBEEF;
        bus.b     = 32'h0BADF00D;
        bus.op    = ~op;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (bus.done !== 1'b0) early_done = 1'b1;
            if (bus.hi !== hold_hi || bus.lo !== hold_lo) held_bad = 1'b1;
            if (disturb && cyc == 10) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.op    = 2'b01;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk({tag, " busy_cycles"}, 32'(cyc), 32'd32);
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " no_early_done"}, 32'(early_done), 32'd0);
        chk({tag, " hilo_held"}, 32'(held_bad), 32'd0);
        chk({tag, " hi"}, bus.hi, exp_hi);
        chk({tag, " lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int dones;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        step();
        step();
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);

        // Start on the first edge after reset release, then back-to-back ops
        reset = 1'b0;
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg7x3", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("div_neg7by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        run_op("divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
        run_op("div_neg_by0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0);
        run_op("mult_max_x2", 2'b00, 32'h7FFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 1'b0);
        run_op("multu_x0", 2'b01, 32'h12345678, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        chk("done_one_cycle", 32'(bus.done), 32'd0);

        // HI/LO moves in IDLE
        bus.a = 32'h1234; bus.mthi = 1'b1;
        step();
        bus.mthi = 1'b0;
        chk("mthi hi", bus.hi, 32'h1234);
        chk("mthi lo", bus.lo, 32'd0);
        bus.a = 32'h5678; bus.mtlo = 1'b1;
        step();
        bus.mtlo = 1'b0;
        chk("mtlo lo", bus.lo, 32'h5678);
        chk("mtlo hi", bus.hi, 32'h1234);
        bus.a = 32'hCAFE; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        step();
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mtboth hi", bus.hi, 32'hCAFE);
        chk("mtboth lo", bus.lo, 32'hCAFE);

        // Start and move on the same edge: start wins
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        run_op("start_vs_mt", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Reset in the middle of a run aborts it silently
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        chk("abort no_done", 32'(dones), 32'd0);
        run_op("after_abort", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
